md_sequencer: RTL and testbench

// - Sequences the shared multiply/divide unit and HI/LO registers for the E stage of the pipelined MIPS core.
// - Accepts one md/mt operation per start pulse and models the fixed multi-cycle latency with a state machine and down-counter.
// - Drives hilo_busy into the stall unit; the stall unit holds md/mf/mt instructions in D while hilo_busy is high.
// - Supports exception flush through cancel, so an operation in E never starts when its instruction is being discarded.

---
 rtl/md_sequencer.sv | 133 +++++++++++++
 tb/tb_md_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// Multiply/divide sequencer for the E stage: computes the result up front,
// then holds it in a pending register until the modelled latency has elapsed.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        cancel,
  output logic        busy,
  output logic        hilo_busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;

  logic        accept;
  logic        is_mult;
  logic        is_div;
  logic        div_by_zero;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [63:0] prod;

  logic        dvd_neg;
  logic        dvs_neg;
  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] dvs_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign accept      = start & ~cancel;
  assign is_mult     = (op == OP_MULT) || (op == OP_MULTU);
  assign is_div      = (op == OP_DIV)  || (op == OP_DIVU);
  assign div_by_zero = (rt_val == 32'd0);

  // The stall unit must see the dependency in the accept cycle itself.
  assign hilo_busy = busy | (accept & (is_mult | is_div));

  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};
  assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign prod   = (op == OP_MULT) ? prod_s : prod_u;

  // Signed divide via magnitudes: quotient truncates toward zero and the
  // remainder follows the dividend. 0x80000000/-1 wraps back to 0x80000000.
  assign dvd_neg  = (op == OP_DIV) & rs_val[31];
  assign dvs_neg  = (op == OP_DIV) & rt_val[31];
  assign dvd_mag  = dvd_neg ? (32'd0 - rs_val) : rs_val;
  assign dvs_mag  = dvs_neg ? (32'd0 - rt_val) : rt_val;
  assign dvs_safe = div_by_zero ? 32'd1 : dvs_mag;
  assign q_mag    = dvd_mag / dvs_safe;
  assign r_mag    = dvd_mag % dvs_safe;
  assign quot     = (dvd_neg ^ dvs_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem      = dvd_neg ? (32'd0 - r_mag) : r_mag;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mult) begin
              pend_hi <= prod[63:32];
              pend_lo <= prod[31:0];
              cnt     <= MULT_LOAD;
              busy    <= 1'b1;
              state   <= RUN;
            end else if (is_div && !div_by_zero) begin
              pend_hi <= rem;
              pend_lo <= quot;
              cnt     <= DIV_LOAD;
              busy    <= 1'b1;
              state   <= RUN;
            end else if (op == OP_MTHI) begin
              hi <= rs_val;
            end else if (op == OP_MTLO) begin
              lo <= rs_val;
            end
          end
        end
        RUN: begin
          // start/cancel are ignored here: the in-flight op is already committed.
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_start_in_run: assert property (@(posedge clk) disable iff (!reset)
    !(state == RUN && start && !cancel));

endmodule

// File: tb/tb_md_sequencer.sv
// Scoreboard bench for md_sequencer: completions are checked by a monitor on
// busy falling; immediate effects (MT, cancel, reset) are checked inline.
module tb_md_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        cancel;
  logic        busy;
  logic        hilo_busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];

  md_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .cancel    (cancel),
    .busy      (busy),
    .hilo_busy (hilo_busy),
    .hi        (hi),
    .lo        (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input logic [31:0] h, input logic [31:0] l, input int c);
    exp_t e;
    e.name   = name;
    e.hi     = h;
    e.lo     = l;
    e.cycles = c;
    exp_q.push_back(e);
  endtask

  // Drives one start cycle, checks hilo_busy inside it, and returns just after the accept edge.
  task automatic apply_stimulus(input string name, input logic [2:0] o, input logic [31:0] rs,
                                input logic [31:0] rt, input logic c, input logic exp_hb);
    @(posedge clk);
    #1;
    start  = 1'b1;
    op     = o;
    rs_val = rs;
    rt_val = rt;
    cancel = c;
    #1;
    check_output({name, " hilo_busy"}, {31'd0, hilo_busy}, {31'd0, exp_hb});
    @(posedge clk);
    #1;
    start  = 1'b0;
    cancel = 1'b0;
    op     = 3'd0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    check_output({name, " completes"}, {31'd0, done}, 32'd1);
  endtask

  task automatic check_quiet(input string name, input logic [31:0] eh, input logic [31:0] el);
    check_output({name, " hi"}, hi, eh);
    check_output({name, " lo"}, lo, el);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output({name, " busy low"}, {31'd0, busy}, 32'd0);
    end
  endtask

  // Monitor: busy falling marks a completed op; compare HI/LO and busy length.
  initial begin
    logic prev_busy;
    int   run;
    exp_t e;
    prev_busy = 1'b0;
    run       = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_busy = 1'b0;
        run       = 0;
      end else begin
        if (busy) begin
          run++;
        end else if (prev_busy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected completion: got hi=%h lo=%h expected none", hi, lo);
          end else begin
            e = exp_q.pop_front();
            check_output({e.name, " hi"}, hi, e.hi);
            check_output({e.name, " lo"}, lo, e.lo);
            check_output({e.name, " busy cycles"}, 32'(run), 32'(e.cycles));
          end
          run = 0;
        end
        prev_busy = busy;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit seen;
    reset  = 1'b0;
    start  = 1'b0;
    op     = 3'd0;
    rs_val = 32'd0;
    rt_val = 32'd0;
    cancel = 1'b0;
    #3;
    check_output("reset hi", hi, 32'd0);
    check_output("reset lo", lo, 32'd0);
    check_output("reset busy", {31'd0, busy}, 32'd0);
    check_output("reset hilo_busy", {31'd0, hilo_busy}, 32'd0);
    #9;
    reset = 1'b1;

    push_exp("mult", 32'hFFFFFFFF, 32'hFFFFFFF1, 5);
    apply_stimulus("mult", 3'd1, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b1);
    wait_idle("mult");

    push_exp("multu", 32'h00000004, 32'hFFFFFFF1, 5);
    apply_stimulus("multu", 3'd2, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b1);
    wait_idle("multu");

    push_exp("divu 7/2", 32'd1, 32'd3, 10);
    apply_stimulus("divu 7/2", 3'd4, 32'd7, 32'd2, 1'b0, 1'b1);
    wait_idle("divu 7/2");

    push_exp("div -7/2", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    apply_stimulus("div -7/2", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
    wait_idle("div -7/2");

    push_exp("div min/-1", 32'd0, 32'h80000000, 10);
    apply_stimulus("div min/-1", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
    wait_idle("div min/-1");

    apply_stimulus("cancelled mult", 3'd1, 32'd3, 32'd4, 1'b1, 1'b0);
    check_quiet("cancelled mult", 32'd0, 32'h80000000);

    apply_stimulus("reserved op", 3'd7, 32'd3, 32'd4, 1'b0, 1'b0);
    check_quiet("reserved op", 32'd0, 32'h80000000);

    apply_stimulus("mthi", 3'd5, 32'h12345678, 32'd0, 1'b0, 1'b0);
    check_quiet("mthi", 32'h12345678, 32'h80000000);

    apply_stimulus("mtlo", 3'd6, 32'hCAFEF00D, 32'd0, 1'b0, 1'b0);
    check_quiet("mtlo", 32'h12345678, 32'hCAFEF00D);

    apply_stimulus("div by zero", 3'd3, 32'd5, 32'd0, 1'b0, 1'b1);
    check_quiet("div by zero", 32'h12345678, 32'hCAFEF00D);

    apply_stimulus("divu by zero", 3'd4, 32'd9, 32'd0, 1'b0, 1'b1);
    check_quiet("divu by zero", 32'h12345678, 32'hCAFEF00D);

    push_exp("mult with cancel mid-run", 32'd0, 32'd42, 5);
    apply_stimulus("mult with cancel mid-run", 3'd1, 32'd6, 32'd7, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    wait_idle("mult with cancel mid-run");

    // Async reset during RUN cycle 3 of a divide; the aborted op has no expectation.
    apply_stimulus("div aborted", 3'd3, 32'd100, 32'd7, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_output("abort busy", {31'd0, busy}, 32'd0);
    check_output("abort hi", hi, 32'd0);
    check_output("abort lo", lo, 32'd0);
    @(negedge clk);
    #2;
    reset = 1'b1;

    push_exp("mult after reset", 32'd1, 32'd0, 5);
    apply_stimulus("mult after reset", 3'd1, 32'h00010000, 32'h00010000, 1'b0, 1'b1);
    wait_idle("mult after reset");

    push_exp("b2b first", 32'd0, 32'd1, 5);
    apply_stimulus("b2b first", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1'b1;
    end
    check_output("b2b first done", {31'd0, seen}, 32'd1);
    push_exp("b2b second", 32'd0, 32'hFFFFFFFE, 5);
    start  = 1'b1;
    op     = 3'd1;
    rs_val = 32'h7FFFFFFF;
    rt_val = 32'd2;
    #1;
    check_output("b2b second hilo_busy", {31'd0, hilo_busy}, 32'd1);
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'd0;
    wait_idle("b2b second");

    repeat (3) @(negedge clk);
    check_output("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
